// File: rtl/branch_pkg.sv
// Shared constants for the branch resolution unit: funct3 encodings and stats width.
// Optional statistics counters are enabled with BRANCH_UNIT_STATS_EN.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int STAT_W = 32;

endpackage

// File: rtl/branch_unit_if.sv
// Request/response bundle between the ID/EX latch, the branch unit and the PC-select logic.
// master = upstream/downstream environment, slave = the branch unit.
interface branch_unit_if #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_funct3;
  logic [DATA_SIZE-1:0] in_rs1;
  logic [DATA_SIZE-1:0] in_rs2;
  logic [ADDR_SIZE-1:0] in_pc;
  logic [ADDR_SIZE-1:0] in_imm;
  logic                 in_pred_taken;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_taken;
  logic                 out_mispredict;
  logic [ADDR_SIZE-1:0] out_redirect_pc;
  logic                 out_illegal;
  logic                 out_misaligned;

  modport master (
    output in_valid, in_funct3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken, out_ready,
    input  in_ready, out_valid, out_taken, out_mispredict, out_redirect_pc,
           out_illegal, out_misaligned
  );

  modport slave (
    input  in_valid, in_funct3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken, out_ready,
    output in_ready, out_valid, out_taken, out_mispredict, out_redirect_pc,
           out_illegal, out_misaligned
  );
endinterface

// File: rtl/branch_cmp.sv
// Combinational operand comparator: equality, signed less-than, unsigned less-than.
module branch_cmp #(
  parameter int DATA_SIZE = 32
) (
  input  logic [DATA_SIZE-1:0] a,
  input  logic [DATA_SIZE-1:0] b,
  output logic                 eq,
  output logic                 slt,
  output logic                 ult
);

  logic signed [DATA_SIZE-1:0] a_s;
  logic signed [DATA_SIZE-1:0] b_s;

  assign a_s = a;
  assign b_s = b;

  assign eq  = (a == b);
  assign slt = (a_s < b_s);
  assign ult = (a < b);

endmodule

// File: rtl/branch_unit.sv
// Pipelined branch resolution unit (1 or 2 stages) with valid/ready on both sides.
// Define BRANCH_UNIT_STATS_EN to add branch/taken/mispredict counters.
module branch_unit
  import branch_pkg::*;
#(
  parameter int DATA_SIZE   = 32,
  parameter int ADDR_SIZE   = 32,
  parameter int PIPE_STAGES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  branch_unit_if.slave      bus
`ifdef BRANCH_UNIT_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_mispredicts
`endif
);

  typedef struct packed {
    logic                 taken;
    logic                 mispredict;
    logic                 illegal;
    logic                 misaligned;
    logic [ADDR_SIZE-1:0] redirect;
  } res_t;

  function automatic res_t resolve(
    input logic [2:0]           f3,
    input logic                 eq,
    input logic                 slt,
    input logic                 ult,
    input logic [ADDR_SIZE-1:0] target,
    input logic [ADDR_SIZE-1:0] fall,
    input logic                 pred
  );
    res_t r;
    logic cond;
    logic ill;
    cond = 1'b0;
    ill  = 1'b0;
    case (f3)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = !eq;
      F3_BLT:  cond = slt;
      F3_BGE:  cond = !slt;
      F3_BLTU: cond = ult;
      F3_BGEU: cond = !ult;
      default: ill  = 1'b1;
    endcase
    r.taken      = cond;
    r.illegal    = ill;
    r.misaligned = cond && (target[1:0] != 2'b00);
    r.mispredict = (cond != pred) || ill || r.misaligned;
    r.redirect   = cond ? target : fall;
    return r;
  endfunction

  logic                 eq_c;
  logic                 slt_c;
  logic                 ult_c;
  logic [ADDR_SIZE-1:0] target_c;
  logic [ADDR_SIZE-1:0] fall_c;

  branch_cmp #(.DATA_SIZE(DATA_SIZE)) u_cmp (
    .a   (bus.in_rs1),
    .b   (bus.in_rs2),
    .eq  (eq_c),
    .slt (slt_c),
    .ult (ult_c)
  );

  assign target_c = bus.in_pc + bus.in_imm;
  assign fall_c   = bus.in_pc + ADDR_SIZE'(4);

  logic vld_p1;
  res_t res_p1;
  logic rdy_p1;
  logic up_vld;
  res_t up_res;
  logic in_rdy;

  assign rdy_p1       = !vld_p1 || bus.out_ready;
  assign bus.in_ready = in_rdy && !flush;

  generate
    if (PIPE_STAGES == 1) begin : g_pipe1
      assign up_vld = bus.in_valid;
      assign up_res = resolve(bus.in_funct3, eq_c, slt_c, ult_c, target_c, fall_c,
                              bus.in_pred_taken);
      assign in_rdy = rdy_p1;
    end else if (PIPE_STAGES == 2) begin : g_pipe2
      logic                 vld_p0;
      logic                 rdy_p0;
      logic                 eq_p0;
      logic                 slt_p0;
      logic                 ult_p0;
      logic                 pred_p0;
      logic [2:0]           f3_p0;
      logic [ADDR_SIZE-1:0] target_p0;
      logic [ADDR_SIZE-1:0] fall_p0;

      assign rdy_p0 = !vld_p0 || rdy_p1;

      // Stage A: compare flags and both candidate PCs are captured
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_p0 <= 1'b0;
        end else if (flush) begin
          vld_p0 <= 1'b0;
        end else if (rdy_p0) begin
          vld_p0 <= bus.in_valid;
        end
      end

      always_ff @(posedge clk) begin
        if (rdy_p0 && bus.in_valid) begin
          eq_p0     <= eq_c;
          slt_p0    <= slt_c;
          ult_p0    <= ult_c;
          pred_p0   <= bus.in_pred_taken;
          f3_p0     <= bus.in_funct3;
          target_p0 <= target_c;
          fall_p0   <= fall_c;
        end
      end

      assign up_vld = vld_p0;
      assign up_res = resolve(f3_p0, eq_p0, slt_p0, ult_p0, target_p0, fall_p0, pred_p0);
      assign in_rdy = rdy_p0;
    end else begin : g_bad
      $error("branch_unit: PIPE_STAGES must be 1 or 2");
      assign up_vld = 1'b0;
      assign up_res = '0;
      assign in_rdy = 1'b0;
    end
  endgenerate

  // Output stage: resolved result held until the consumer takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      res_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (rdy_p1) begin
      vld_p1 <= up_vld;
      if (up_vld) begin
        res_p1 <= up_res;
      end
    end
  end

  assign bus.out_valid       = vld_p1;
  assign bus.out_taken       = res_p1.taken;
  assign bus.out_mispredict  = res_p1.mispredict;
  assign bus.out_illegal     = res_p1.illegal;
  assign bus.out_misaligned  = res_p1.misaligned;
  assign bus.out_redirect_pc = res_p1.redirect;

`ifdef BRANCH_UNIT_STATS_EN
  // A result handed over during a flush still counts as delivered
  logic fire;
  assign fire = vld_p1 && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_taken       <= '0;
      stat_mispredicts <= '0;
    end else if (fire) begin
      stat_branches <= stat_branches + 1'b1;
      if (res_p1.taken) begin
        stat_taken <= stat_taken + 1'b1;
      end
      if (res_p1.mispredict) begin
        stat_mispredicts <= stat_mispredicts + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench: one 1-stage and one 2-stage branch_unit against a queue-based reference.
// Honours BRANCH_UNIT_STATS_EN for the statistics counters.
module tb_branch_unit;

  typedef struct packed {
    logic        taken;
    logic        mis;
    logic        ill;
    logic        mal;
    logic [31:0] rpc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid1 = 1'b0, in_valid2 = 1'b0;
  logic        out_ready1 = 1'b1, out_ready2 = 1'b1;
  logic [2:0]  f3 = 3'd0;
  logic [31:0] rs1 = '0, rs2 = '0, pc = '0, imm = '0;
  logic        pred = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int n_out2 = 0;
  logic acc1, acc2;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  branch_unit_if #(.DATA_SIZE(32), .ADDR_SIZE(32)) b1 ();
  branch_unit_if #(.DATA_SIZE(32), .ADDR_SIZE(32)) b2 ();

  assign b1.in_valid = in_valid1;      assign b2.in_valid = in_valid2;
  assign b1.out_ready = out_ready1;    assign b2.out_ready = out_ready2;
  assign b1.in_funct3 = f3;            assign b2.in_funct3 = f3;
  assign b1.in_rs1 = rs1;              assign b2.in_rs1 = rs1;
  assign b1.in_rs2 = rs2;              assign b2.in_rs2 = rs2;
  assign b1.in_pc = pc;                assign b2.in_pc = pc;
  assign b1.in_imm = imm;              assign b2.in_imm = imm;
  assign b1.in_pred_taken = pred;      assign b2.in_pred_taken = pred;

`ifdef BRANCH_UNIT_STATS_EN
  logic [31:0] s1_br, s1_tk, s1_mp, s2_br, s2_tk, s2_mp;
  logic [31:0] e1_br = 0, e1_tk = 0, e1_mp = 0, e2_br = 0, e2_tk = 0, e2_mp = 0;
`endif

  branch_unit #(.DATA_SIZE(32), .ADDR_SIZE(32), .PIPE_STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b1)
`ifdef BRANCH_UNIT_STATS_EN
    , .stat_branches(s1_br), .stat_taken(s1_tk), .stat_mispredicts(s1_mp)
`endif
  );

  branch_unit #(.DATA_SIZE(32), .ADDR_SIZE(32), .PIPE_STAGES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b2)
`ifdef BRANCH_UNIT_STATS_EN
    , .stat_branches(s2_br), .stat_taken(s2_tk), .stat_mispredicts(s2_mp)
`endif
  );

  // Reference: branch rules in plain arithmetic; signed order via sign-bit flip.
  function automatic exp_t ref_model(input logic [2:0] fn, input logic [31:0] a,
                                     input logic [31:0] b, input logic [31:0] p,
                                     input logic [31:0] im, input logic pr);
    exp_t e;
    logic [31:0] tgt, ft, as, bs;
    logic t;
    tgt = p + im;
    ft  = p + 32'd4;
    as  = a ^ 32'h8000_0000;
    bs  = b ^ 32'h8000_0000;
    e.ill = 1'b0;
    case (fn)
      3'd0: t = (a == b);
      3'd1: t = (a != b);
      3'd4: t = (as < bs);
      3'd5: t = (as >= bs);
      3'd6: t = (a < b);
      3'd7: t = (a >= b);
      default: begin t = 1'b0; e.ill = 1'b1; end
    endcase
    e.taken = t;
    e.mal   = t && (tgt % 4 != 0);
    e.mis   = e.ill || e.mal || (t != pr);
    e.rpc   = t ? tgt : ft;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t got;
    @(negedge clk);
    acc1 = b1.in_valid && b1.in_ready;
    acc2 = b2.in_valid && b2.in_ready;
`ifdef BRANCH_UNIT_STATS_EN
    check("stat1_br", s1_br, e1_br); check("stat1_mp", s1_mp, e1_mp);
    check("stat2_br", s2_br, e2_br); check("stat2_tk", s2_tk, e2_tk);
    check("stat1_tk", s1_tk, e1_tk); check("stat2_mp", s2_mp, e2_mp);
`endif
    if (!rst_n) begin
      q1.delete(); q2.delete();
`ifdef BRANCH_UNIT_STATS_EN
      e1_br = 0; e1_tk = 0; e1_mp = 0; e2_br = 0; e2_tk = 0; e2_mp = 0;
`endif
    end else begin
      if (b1.out_valid) begin
        check("u1_out_expected", q1.size() != 0, 1'b1);
        if (q1.size() != 0) begin
          got = {b1.out_taken, b1.out_mispredict, b1.out_illegal, b1.out_misaligned,
                 b1.out_redirect_pc};
          check("u1_result", got, q1[0]);
          if (out_ready1) begin
`ifdef BRANCH_UNIT_STATS_EN
            e1_br++; if (q1[0].taken) e1_tk++; if (q1[0].mis) e1_mp++;
`endif
            void'(q1.pop_front());
          end
        end
      end
      if (b2.out_valid) begin
        check("u2_out_expected", q2.size() != 0, 1'b1);
        if (q2.size() != 0) begin
          got = {b2.out_taken, b2.out_mispredict, b2.out_illegal, b2.out_misaligned,
                 b2.out_redirect_pc};
          check("u2_result", got, q2[0]);
          if (out_ready2) begin
`ifdef BRANCH_UNIT_STATS_EN
            e2_br++; if (q2[0].taken) e2_tk++; if (q2[0].mis) e2_mp++;
`endif
            void'(q2.pop_front());
            n_out2++;
          end
        end
      end
      if (acc1) q1.push_back(ref_model(f3, rs1, rs2, pc, imm, pred));
      if (acc2) q2.push_back(ref_model(f3, rs1, rs2, pc, imm, pred));
      if (flush) begin q1.delete(); q2.delete(); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] im, input logic pr);
    f3 = fn; rs1 = a; rs2 = b; pc = p; imm = im; pred = pr;
  endtask

  task automatic issue1(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] im, input logic pr);
    set_req(fn, a, b, p, im, pr);
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] sa [4];
    logic [31:0] sb [4];
    logic [2:0]  sf [4];
    int idx;

    // Reset
    tick(); tick();
    check("rst_u1_valid", b1.out_valid, 1'b0);
    check("rst_u1_rpc", b1.out_redirect_pc, 32'h0);
    check("rst_u2_valid", b2.out_valid, 1'b0);
    check("rst_u2_flags", {b2.out_taken, b2.out_mispredict, b2.out_illegal, b2.out_misaligned}, 4'h0);
    rst_n = 1'b1;
    check("rst_u1_inready", b1.in_ready, 1'b1);

    // Single-stage directed cases
    issue1(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0);
    check("blt_valid", b1.out_valid, 1'b1);
    check("blt_taken", b1.out_taken, 1'b1);
    check("blt_mis", b1.out_mispredict, 1'b1);
    check("blt_rpc", b1.out_redirect_pc, 32'h120);
    issue1(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0);
    check("bltu_taken", b1.out_taken, 1'b0);
    check("bltu_mis", b1.out_mispredict, 1'b0);
    check("bltu_rpc", b1.out_redirect_pc, 32'h104);
    issue1(3'b111, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0);
    check("bgeu_taken", b1.out_taken, 1'b1);
    issue1(3'b010, 32'h5, 32'h5, 32'h200, 32'h40, 1'b1);
    check("ill_flags", {b1.out_illegal, b1.out_taken, b1.out_mispredict}, 3'b101);
    check("ill_rpc", b1.out_redirect_pc, 32'h204);
    issue1(3'b000, 32'h7, 32'h7, 32'hFFFF_FFFC, 32'h8, 1'b1);
    check("wrap_rpc", b1.out_redirect_pc, 32'h4);
    check("wrap_mal", {b1.out_misaligned, b1.out_mispredict}, 2'b00);
    issue1(3'b000, 32'h7, 32'h7, 32'hFFFF_FFFC, 32'h6, 1'b1);
    check("mal_flags", {b1.out_misaligned, b1.out_mispredict}, 2'b11);
    check("mal_rpc", b1.out_redirect_pc, 32'h2);
    tick();
    check("u1_idle", b1.out_valid, 1'b0);

    // Two-stage stream of four requests with a 3-cycle output stall
    sf[0] = 3'b000; sa[0] = 32'h1;         sb[0] = 32'h1;
    sf[1] = 3'b101; sa[1] = 32'h8000_0000; sb[1] = 32'h0;
    sf[2] = 3'b110; sa[2] = 32'h3;         sb[2] = 32'h9;
    sf[3] = 3'b001; sa[3] = 32'hA;         sb[3] = 32'hA;
    idx = 0;
    n_out2 = 0;
    for (int c = 0; c < 30 && (idx < 4 || q2.size() != 0); c++) begin
      out_ready2 = (c >= 3);
      in_valid2 = (idx < 4);
      if (idx < 4) set_req(sf[idx], sa[idx], sb[idx], 32'h1000 + 32'(idx * 16), 32'h40, idx[0]);
      if (c == 2) begin
        check("stall_accepted", idx, 2);
        check("stall_inready", b2.in_ready, 1'b0);
        check("stall_outvalid", b2.out_valid, 1'b1);
      end
      tick();
      if (acc2) idx++;
    end
    in_valid2 = 1'b0;
    check("stream_accepted", idx, 4);
    check("stream_delivered", n_out2, 4);

    // Flush with two entries in flight
    out_ready2 = 1'b0;
    set_req(3'b000, 32'h2, 32'h2, 32'h300, 32'h10, 1'b0);
    in_valid2 = 1'b1; tick(); tick();
    check("fl_full_valid", b2.out_valid, 1'b1);
    flush = 1'b1;
    check("fl_inready", b2.in_ready, 1'b0);
    tick();
    flush = 1'b0;
    in_valid2 = 1'b0;
    check("fl_cleared", b2.out_valid, 1'b0);
    tick();
    check("fl_dropped", b2.out_valid, 1'b0);

    // Reset mid-stall
    in_valid2 = 1'b1; tick(); tick();
    in_valid2 = 1'b0;
    check("rs_stalled", b2.out_valid, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rs_valid", b2.out_valid, 1'b0);
    check("rs_rpc", b2.out_redirect_pc, 32'h0);
`ifdef BRANCH_UNIT_STATS_EN
    check("rs_stats", {s2_br, s2_tk, s2_mp}, 96'h0);
`endif
    out_ready2 = 1'b1;

    // Randomised traffic on both units
    for (int c = 0; c < 600; c++) begin
      in_valid1  = ($urandom_range(3) != 0);
      in_valid2  = ($urandom_range(3) != 0);
      out_ready1 = ($urandom_range(3) != 0);
      out_ready2 = ($urandom_range(3) != 0);
      flush      = ($urandom_range(31) == 0);
      f3   = 3'($urandom_range(7));
      rs1  = $urandom;
      rs2  = ($urandom_range(3) == 0) ? rs1 : $urandom;
      pc   = ($urandom_range(7) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(15)) : $urandom;
      imm  = ($urandom_range(1) == 0) ? {$urandom} & 32'hFFFF_FFFC : $urandom;
      pred = 1'($urandom_range(1));
      tick();
    end

    // Drain
    in_valid1 = 1'b0; in_valid2 = 1'b0; flush = 1'b0;
    out_ready1 = 1'b1; out_ready2 = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    check("drain_u1", q1.size(), 0);
    check("drain_u2", q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
